// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - start/stop/clear sequencer that turns a free-running counter into a timer
// Optional match-event counter enabled by defining CNT_CTRL_MATCH_CNT_EN.
module counter_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MATCH_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   cmd_start,
  input  logic                   cmd_stop,
  input  logic                   cmd_clear,
  input  logic                   cfg_periodic,
  input  logic [WIDTH-1:0]       cfg_limit,
  input  logic [WIDTH-1:0]       cnt_val,
  output logic                   cnt_en,
  output logic                   cnt_clr,
  output logic                   match,
  output logic                   done,
  output logic                   busy,
  output logic [MATCH_CNT_W-1:0] match_cnt
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, PAUSE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             periodic_q, periodic_d;
  logic             clr_q, clr_d;
  logic             hit_q, hit_d;
  logic             cnt_en_q, cnt_en_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             latch_cfg;
  logic [WIDTH-1:0] pred_val;

  assign match   = (state_q == RUN) && hit_q;
  assign cnt_clr = clr_q || (state_q == CLEAR) || (match && periodic_q);
  assign cnt_en  = cnt_en_q;
  assign done    = done_q;
  assign busy    = busy_q;

  always_comb begin
    state_d   = state_q;
    clr_d     = 1'b0;
    latch_cfg = 1'b0;
    if (cmd_clear) begin
      state_d = IDLE;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_start) begin
            state_d   = CLEAR;
            latch_cfg = 1'b1;
          end
        end
        CLEAR: state_d = RUN;
        RUN: begin
          if (hit_q && !periodic_q) begin
            state_d = DONE;
          end else if (cmd_stop) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (cmd_start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (cmd_start) begin
            state_d   = CLEAR;
            latch_cfg = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    limit_d    = latch_cfg ? cfg_limit : limit_q;
    periodic_d = latch_cfg ? cfg_periodic : periodic_q;

    // The compare is registered, so predict the counter's next value from
    // the enable/clear we are driving this cycle and compare that instead.
    if (cnt_clr) begin
      pred_val = '0;
    end else if (cnt_en_q) begin
      pred_val = cnt_val + WIDTH'(1);
    end else begin
      pred_val = cnt_val;
    end
    hit_d = (pred_val == limit_d);

    cnt_en_d = (state_d == RUN) && !(hit_d && !periodic_d);
    done_d   = (state_d == DONE);
    busy_d   = (state_d == CLEAR) || (state_d == RUN);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      clr_q      <= 1'b1;
      hit_q      <= 1'b0;
      cnt_en_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      clr_q      <= clr_d;
      hit_q      <= hit_d;
      cnt_en_q   <= cnt_en_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

`ifdef CNT_CTRL_MATCH_CNT_EN
  logic [MATCH_CNT_W-1:0] match_cnt_q, match_cnt_d;

  always_comb begin
    match_cnt_d = match_cnt_q;
    if (cmd_clear) begin
      match_cnt_d = '0;
    end else if (match) begin
      match_cnt_d = match_cnt_q + MATCH_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      match_cnt_q <= '0;
    end else begin
      match_cnt_q <= match_cnt_d;
    end
  end

  assign match_cnt = match_cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - self-checking bench for counter_ctrl with a behavioural counter
module tb_counter_ctrl;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        cmd_start = 1'b0, cmd_stop = 1'b0, cmd_clear = 1'b0;
  logic        cfg_periodic = 1'b0;
  logic [31:0] cfg_limit = '0;
  logic [31:0] cnt_val = '0;
  logic        cnt_en, cnt_clr, match, done, busy;
  logic [7:0]  match_cnt;

`ifdef CNT_CTRL_MATCH_CNT_EN
  localparam int MC_ON = 1;
`else
  localparam int MC_ON = 0;
`endif

  counter_ctrl #(.WIDTH(32), .MATCH_CNT_W(8)) dut (
    .clk(clk), .n_reset(n_reset),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_clear(cmd_clear),
    .cfg_periodic(cfg_periodic), .cfg_limit(cfg_limit), .cnt_val(cnt_val),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .match(match), .done(done),
    .busy(busy), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_clr) cnt_val <= '0;
    else if (cnt_en) cnt_val <= cnt_val + 32'd1;
  end

  typedef struct packed {
    logic [31:0] cnt;
    logic m, en, clr, d, b;
  } exp_t;

  typedef struct packed {
    logic c, s, st, p;
    logic [31:0] lim;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t E(input logic [31:0] cnt, input logic m, en, clr, d, b);
    E = {cnt, m, en, clr, d, b};
  endfunction

  function automatic vec_t V(input logic c, s, st, p, input logic [31:0] lim, input exp_t e);
    V = {c, s, st, p, lim, e};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  // Drive one cycle of commands, expect outputs in that same cycle.
  task automatic step(input string nm, input logic c, s, st, p, input logic [31:0] lim,
                      input logic [31:0] cnt, input logic m, en, clr, d, b);
    exp_t want, got;
    @(posedge clk);
    #1;
    cmd_clear = c; cmd_stop = s; cmd_start = st; cfg_periodic = p; cfg_limit = lim;
    sb.push_back(E(cnt, m, en, clr, d, b));
    @(negedge clk);
    got  = {cnt_val, match, cnt_en, cnt_clr, done, busy};
    want = sb.pop_front();
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got cnt=%0d m=%b en=%b clr=%b done=%b busy=%b want cnt=%0d m=%b en=%b clr=%b done=%b busy=%b",
               nm, got.cnt, got.m, got.en, got.clr, got.d, got.b,
               want.cnt, want.m, want.en, want.clr, want.d, want.b);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // one-shot, limit 5; cfg wiggles after start must be ignored
    tbl[0]  = V(0, 0, 1, 0, 5,  E(0, 0, 0, 0, 0, 0));
    tbl[1]  = V(0, 0, 0, 1, 2,  E(0, 0, 0, 1, 0, 1));
    tbl[2]  = V(0, 0, 0, 1, 2,  E(0, 0, 1, 0, 0, 1));
    tbl[3]  = V(0, 0, 1, 0, 9,  E(1, 0, 1, 0, 0, 1));
    tbl[4]  = V(0, 0, 0, 0, 9,  E(2, 0, 1, 0, 0, 1));
    tbl[5]  = V(0, 0, 0, 0, 9,  E(3, 0, 1, 0, 0, 1));
    tbl[6]  = V(0, 0, 0, 0, 9,  E(4, 0, 1, 0, 0, 1));
    tbl[7]  = V(0, 1, 0, 0, 9,  E(5, 1, 0, 0, 0, 1));
    tbl[8]  = V(0, 1, 0, 0, 9,  E(5, 0, 0, 0, 1, 0));
    tbl[9]  = V(1, 0, 0, 0, 9,  E(5, 0, 0, 0, 1, 0));
    tbl[10] = V(0, 0, 0, 0, 9,  E(5, 0, 0, 1, 0, 0));
    tbl[11] = V(0, 0, 0, 0, 9,  E(0, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", {31'd0, cnt_en}, 0);
    chk("rst_clr", {31'd0, cnt_clr}, 1);
    chk("rst_done_busy_match", {29'd0, done, busy, match}, 0);
    chk("rst_match_cnt", {24'd0, match_cnt}, 0);
    n_reset = 1'b1;
    #1;
    chk("rel_clr", {31'd0, cnt_clr}, 1);

    for (int i = 0; i < 12; i++)
      step($sformatf("oneshot_row%0d", i), tbl[i].c, tbl[i].s, tbl[i].st, tbl[i].p, tbl[i].lim,
           tbl[i].e.cnt, tbl[i].e.m, tbl[i].e.en, tbl[i].e.clr, tbl[i].e.d, tbl[i].e.b);

    // periodic, limit 3: 20 RUN cycles, 5 matches
    step("per_idle",  0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0);
    step("per_clear", 0, 0, 0, 0, 7, 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 20; k++)
      step($sformatf("per_run%0d", k), 0, 0, 0, 0, 7, k % 4, (k % 4) == 3, 1, (k % 4) == 3, 0, 1);
    step("per_run20", 1, 0, 0, 0, 7, 0, 0, 1, 0, 0, 1);
    chk("per_match_cnt", {24'd0, match_cnt}, 5 * MC_ON);
    step("per_clr",   0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0);
    step("per_idle2", 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0);
    chk("per_match_cnt_zeroed", {24'd0, match_cnt}, 0);

    // pause / resume, limit 10 one-shot
    step("pr_idle",  0, 0, 1, 0, 10, 0, 0, 0, 0, 0, 0);
    step("pr_clear", 0, 0, 0, 0, 10, 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 3; k++)
      step($sformatf("pr_run%0d", k), 0, 0, 0, 0, 10, k, 0, 1, 0, 0, 1);
    step("pr_stop", 0, 1, 0, 0, 10, 3, 0, 1, 0, 0, 1);
    for (int k = 0; k < 6; k++)
      step($sformatf("pr_pause%0d", k), 0, k == 1, k == 5, 1, 3, 4, 0, 0, 0, 0, 0);
    for (int k = 4; k < 10; k++)
      step($sformatf("pr_resume%0d", k), 0, 0, 0, 0, 10, k, 0, 1, 0, 0, 1);
    step("pr_match", 0, 0, 0, 0, 10, 10, 1, 0, 0, 0, 1);
    step("pr_done",  0, 0, 1, 1, 2, 10, 0, 0, 0, 1, 0);

    // all three commands in one RUN cycle: clear wins
    step("pri_clear", 0, 0, 0, 0, 9, 10, 0, 0, 1, 0, 1);
    step("pri_run0",  0, 0, 0, 0, 9, 0, 0, 1, 0, 0, 1);
    step("pri_all3",  1, 1, 1, 0, 9, 1, 0, 1, 0, 0, 1);
    step("pri_idle",  0, 0, 0, 0, 9, 2, 0, 0, 1, 0, 0);
    step("pri_idle2", 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0);

    // stop in the match cycle, periodic limit 2 -> match, clear, PAUSE at 0
    step("sm_idle",  0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    step("sm_clear", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step("sm_run0",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step("sm_run1",  0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
    step("sm_match", 0, 1, 0, 0, 0, 2, 1, 1, 1, 0, 1);
    step("sm_pause", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("sm_pause2",1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("sm_idle2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // limit 0 periodic: match every RUN cycle
    step("z0p_idle",  0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step("z0p_clear", 0, 0, 0, 0, 5, 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 5; k++)
      step($sformatf("z0p_run%0d", k), k == 4, 0, 0, 0, 5, 0, 1, 1, 1, 0, 1);
    step("z0p_clr",  0, 0, 0, 0, 5, 0, 0, 0, 1, 0, 0);

    // limit 0 one-shot: single match then DONE
    step("z0o_idle",  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("z0o_clear", 0, 0, 0, 0, 5, 0, 0, 0, 1, 0, 1);
    step("z0o_run",   0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 1);
    step("z0o_done",  0, 0, 0, 0, 5, 0, 0, 0, 0, 1, 0);
    chk("z0o_match_cnt", {24'd0, match_cnt}, MC_ON);
    step("z0o_done2", 1, 0, 0, 0, 5, 0, 0, 0, 0, 1, 0);
    step("z0o_idle2", 0, 0, 0, 0, 5, 0, 0, 0, 1, 0, 0);

    // async reset in the middle of RUN
    step("ar_idle",  0, 0, 1, 0, 100, 0, 0, 0, 0, 0, 0);
    step("ar_clear", 0, 0, 0, 0, 100, 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 3; k++)
      step($sformatf("ar_run%0d", k), 0, 0, 0, 0, 100, k, 0, 1, 0, 0, 1);
    #2;
    n_reset = 1'b0;
    #1;
    chk("ar_en", {31'd0, cnt_en}, 0);
    chk("ar_clr", {31'd0, cnt_clr}, 1);
    chk("ar_busy_done", {30'd0, busy, done}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("ar_cnt_zero", cnt_val, 0);
    n_reset = 1'b1;
    step("ar_after", 0, 0, 0, 0, 100, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
